// File: rtl/fir_pkg.sv
// ---------------------------------------------------------------------------
// fir_pkg
// Shared definitions for the FIR coefficient loader.
//   state_t     : loader sequencing states (IDLE, SETUP, CLK1, GAP1, CLK2,
//                 GAP2, DONE)
//   *_DEF       : default parameter values for coef_loader
//   COEF_BITS   : bits in one coefficient chain load (WIDTH*NTAPS)
//   BIT_CYCLES  : ph1 cycles spent on each shifted bit
//   max2()      : constant helper for sizing counters
// ---------------------------------------------------------------------------
package fir_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SETUP = 3'd1,
      CLK1  = 3'd2,
      GAP1  = 3'd3,
      CLK2  = 3'd4,
      GAP2  = 3'd5,
      DONE  = 3'd6
   } state_t;

   localparam int WIDTH_DEF = 8;
   localparam int NTAPS_DEF = 4;
   localparam int HIGH_DEF  = 1;
   localparam int GAP_DEF   = 1;

   localparam int COEF_BITS  = WIDTH_DEF * NTAPS_DEF;
   localparam int BIT_CYCLES = 1 + 2 * HIGH_DEF + 2 * GAP_DEF;

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/coef_phase_gen.sv
// ---------------------------------------------------------------------------
// coef_phase_gen
// Sequencer and timer for one load. Walks SETUP -> CLK1 -> GAP1 -> CLK2 ->
// GAP2 for every bit and produces the registered two-phase non-overlapping
// shift clocks.
// Ports:
//   ph1        in  : system clock (rising edge)
//   reset      in  : asynchronous active-low reset
//   go         in  : start accepted this edge (only meaningful in IDLE)
//   last       in  : the bit now being shifted is the final one
//   stop       in  : end the load after the current bit without DONE
//   state      out : current sequencer state (also used for debug)
//   shift_clk1 out : master shift clock, high during CLK1
//   shift_clk2 out : slave shift clock, high during CLK2
//   bit_end    out : high in the final GAP2 cycle of each bit
// ---------------------------------------------------------------------------
module coef_phase_gen
   import fir_pkg::*;
#(
   parameter int HIGH_CYCLES = HIGH_DEF,
   parameter int GAP_CYCLES  = GAP_DEF
) (
   input  logic   ph1,
   input  logic   reset,
   input  logic   go,
   input  logic   last,
   input  logic   stop,
   output state_t state,
   output logic   shift_clk1,
   output logic   shift_clk2,
   output logic   bit_end
);

   localparam int TW = $clog2(max2(HIGH_CYCLES, GAP_CYCLES) + 1);
   localparam logic [TW-1:0] H_LAST = TW'(HIGH_CYCLES - 1);
   localparam logic [TW-1:0] G_LAST = TW'(GAP_CYCLES - 1);

   logic [TW-1:0] tmr;

   assign bit_end = (state == GAP2) && (tmr == G_LAST);

   // Clock outputs are assigned on the same edge that enters/leaves the
   // CLK phases, so they line up exactly with the registered state.
   always_ff @(posedge ph1 or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         tmr        <= '0;
         shift_clk1 <= 1'b0;
         shift_clk2 <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (go) state <= SETUP;
            end
            SETUP: begin
               state      <= CLK1;
               tmr        <= '0;
               shift_clk1 <= 1'b1;
            end
            CLK1: begin
               if (tmr == H_LAST) begin
                  state      <= GAP1;
                  tmr        <= '0;
                  shift_clk1 <= 1'b0;
               end else begin
                  tmr <= tmr + 1'b1;
               end
            end
            GAP1: begin
               if (tmr == G_LAST) begin
                  state      <= CLK2;
                  tmr        <= '0;
                  shift_clk2 <= 1'b1;
               end else begin
                  tmr <= tmr + 1'b1;
               end
            end
            CLK2: begin
               if (tmr == H_LAST) begin
                  state      <= GAP2;
                  tmr        <= '0;
                  shift_clk2 <= 1'b0;
               end else begin
                  tmr <= tmr + 1'b1;
               end
            end
            GAP2: begin
               if (tmr == G_LAST) begin
                  tmr <= '0;
                  if (stop)      state <= IDLE;
                  else if (last) state <= DONE;
                  else           state <= SETUP;
               end else begin
                  tmr <= tmr + 1'b1;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state      <= IDLE;
               tmr        <= '0;
               shift_clk1 <= 1'b0;
               shift_clk2 <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/coef_loader.sv
// ---------------------------------------------------------------------------
// coef_loader
// Loads the FIR coefficient shift chain: latches NTAPS packed coefficients
// and shifts them out MSB first on shiftIn, qualified by the two-phase
// non-overlapping clocks shiftClk1/shiftClk2.
// Optional feature macro: COEF_LOADER_ABORT_EN (adds the abort input).
// Ports:
//   ph1       in  : system clock (rising edge)
//   reset     in  : asynchronous active-low reset
//   start     in  : load request, sampled only while busy=0
//   coefIn    in  : {c[NTAPS-1], ..., c[1], c[0]}
//   abort     in  : (COEF_LOADER_ABORT_EN only) finish current bit then stop
//   shiftIn   out : serial data to the first coefficient register
//   shiftClk1 out : master shift clock
//   shiftClk2 out : slave shift clock
//   busy      out : load in progress
//   done      out : one-cycle pulse after the final bit
//   dbg_state out : sequencer state
// Handshake: a load is accepted on any rising ph1 edge with start=1 while the
// sequencer is IDLE (busy=0); busy rises the next cycle and stays high
// through the DONE cycle, during which start is not accepted.
// ---------------------------------------------------------------------------
module coef_loader
   import fir_pkg::*;
#(
   parameter int WIDTH       = WIDTH_DEF,
   parameter int NTAPS       = NTAPS_DEF,
   parameter int HIGH_CYCLES = HIGH_DEF,
   parameter int GAP_CYCLES  = GAP_DEF
) (
   input  logic                   ph1,
   input  logic                   reset,
   input  logic                   start,
   input  logic [WIDTH*NTAPS-1:0] coefIn,
`ifdef COEF_LOADER_ABORT_EN
   input  logic                   abort,
`endif
   output logic                   shiftIn,
   output logic                   shiftClk1,
   output logic                   shiftClk2,
   output logic                   busy,
   output logic                   done,
   output state_t                 dbg_state
);

   localparam int NB = WIDTH * NTAPS;
   localparam int CW = (NB > 1) ? $clog2(NB) : 1;
   localparam logic [CW-1:0] LAST_BIT = CW'(NB - 1);

   state_t        state;
   logic          go;
   logic          last;
   logic          stop;
   logic          bit_end;
   logic [NB-1:0] shadow;
   logic [CW-1:0] bit_cnt;

   assign go        = start && (state == IDLE);
   assign last      = (bit_cnt == '0);
   assign dbg_state = state;

`ifdef COEF_LOADER_ABORT_EN
   // Remembers an abort seen anywhere in the current bit so the bit can run
   // to the end of GAP2 before the load is dropped.
   logic abort_pend;

   assign stop = abort | abort_pend;

   always_ff @(posedge ph1 or negedge reset) begin
      if (!reset) begin
         abort_pend <= 1'b0;
      end else if ((state == IDLE) || bit_end) begin
         abort_pend <= 1'b0;
      end else if (abort && (state != DONE)) begin
         abort_pend <= 1'b1;
      end
   end
`else
   assign stop = 1'b0;
`endif

   coef_phase_gen #(
      .HIGH_CYCLES (HIGH_CYCLES),
      .GAP_CYCLES  (GAP_CYCLES)
   ) u_phase (
      .ph1        (ph1),
      .reset      (reset),
      .go         (go),
      .last       (last),
      .stop       (stop),
      .state      (state),
      .shift_clk1 (shiftClk1),
      .shift_clk2 (shiftClk2),
      .bit_end    (bit_end)
   );

   // shiftIn only moves on the go edge and on bit_end edges, both of which
   // fall outside the CLK phases, so data is stable under every clock pulse.
   always_ff @(posedge ph1 or negedge reset) begin
      if (!reset) begin
         shadow  <= '0;
         bit_cnt <= '0;
         shiftIn <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         done <= 1'b0;
         if (go) begin
            shadow  <= coefIn;
            bit_cnt <= LAST_BIT;
            shiftIn <= coefIn[NB-1];
            busy    <= 1'b1;
         end else if (state == DONE) begin
            busy <= 1'b0;
         end else if (bit_end) begin
            if (stop) begin
               busy    <= 1'b0;
               shiftIn <= 1'b0;
            end else if (last) begin
               done    <= 1'b1;
               shiftIn <= 1'b0;
            end else begin
               bit_cnt <= bit_cnt - 1'b1;
               shadow  <= {shadow[NB-2:0], 1'b0};
               shiftIn <= shadow[NB-2];
            end
         end
      end
   end

endmodule

// File: tb/tb_coef_loader.sv
// ---------------------------------------------------------------------------
// tb_coef_loader
// Self-checking bench for coef_loader. Instance u_a uses default timing,
// u_b uses HIGH_CYCLES=2 / GAP_CYCLES=3. A datapath model (master latch on
// shiftClk1, chain shift on shiftClk2) rebuilds the loaded word, and the
// expected latency comes from the closed-form load time.
// ---------------------------------------------------------------------------
module tb_coef_loader;
   import fir_pkg::*;

   localparam int NB = 32;

   // ---------------- clock / reset ----------------
   logic ph1 = 1'b0;
   always #5 ph1 = ~ph1;

   logic        rst_n;
   logic        start_r;
   logic [31:0] coef_r;
   logic        abort_r;
   logic        sel;

   logic start_a, start_b;
   assign start_a = start_r & ~sel;
   assign start_b = start_r & sel;

   logic   si_a, c1_a, c2_a, busy_a, done_a;
   logic   si_b, c1_b, c2_b, busy_b, done_b;
   state_t dbg_a, dbg_b;

   coef_loader u_a (
      .ph1       (ph1),
      .reset     (rst_n),
      .start     (start_a),
      .coefIn    (coef_r),
`ifdef COEF_LOADER_ABORT_EN
      .abort     (abort_r & ~sel),
`endif
      .shiftIn   (si_a),
      .shiftClk1 (c1_a),
      .shiftClk2 (c2_a),
      .busy      (busy_a),
      .done      (done_a),
      .dbg_state (dbg_a)
   );

   coef_loader #(.HIGH_CYCLES(2), .GAP_CYCLES(3)) u_b (
      .ph1       (ph1),
      .reset     (rst_n),
      .start     (start_b),
      .coefIn    (coef_r),
`ifdef COEF_LOADER_ABORT_EN
      .abort     (abort_r & sel),
`endif
      .shiftIn   (si_b),
      .shiftClk1 (c1_b),
      .shiftClk2 (c2_b),
      .busy      (busy_b),
      .done      (done_b),
      .dbg_state (dbg_b)
   );

   logic m_si, m_c1, m_c2, m_busy, m_done;
   assign m_si   = sel ? si_b   : si_a;
   assign m_c1   = sel ? c1_b   : c1_a;
   assign m_c2   = sel ? c2_b   : c2_a;
   assign m_busy = sel ? busy_b : busy_a;
   assign m_done = sel ? done_b : done_a;

   // ---------------- scoreboard ----------------
   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   function automatic int lat(input int h, input int g);
      return NB * (1 + 2 * h + 2 * g) + 1;
   endfunction

   // results of the most recent run_load
   int          r_done_c, r_done_c2, r_busy_fall, r_clk2, r_viol, r_ndone;
   logic [31:0] r_chain, r_seq;
   logic [31:0] exp_q[$];   // shiftIn bits expected, MSB first
   int          r_seq_err;
   bit          r_timeout;
   logic        r_pre_clk1, r_rst_c1, r_rst_c2, r_rst_busy, r_rst_done, r_rst_si;

   // ---------------- driver / monitor ----------------
   task automatic run_load(input logic [31:0] w, input int repulse_at, input int reset_at,
                           input int abort_at, input bit hold);
      int   c;
      logic pc1, pc2, pbusy, psi, master;
      logic [31:0] e;
      r_done_c = 0; r_done_c2 = 0; r_busy_fall = 0; r_clk2 = 0; r_viol = 0;
      r_ndone = 0; r_chain = '0; r_seq = '0; r_seq_err = 0; r_timeout = 0;
      exp_q.delete();
      for (int i = NB - 1; i >= 0; i--) exp_q.push_back({31'd0, w[i]});
      @(negedge ph1);
      start_r = 1'b1; coef_r = w; abort_r = 1'b0;
      c = 0; pc1 = 0; pc2 = 0; pbusy = 0; psi = 0; master = 0;
      while (1) begin
         @(posedge ph1); c++;
         @(negedge ph1);
         if (m_c1 && m_c2) r_viol++;
         if ((m_c1 || m_c2) && (pc1 || pc2) && (m_si !== psi)) r_viol++;
         if (m_c1 && !pc1) begin
            master = m_si;
            r_seq  = {r_seq[30:0], m_si};
            if (exp_q.size() == 0) r_seq_err++;
            else begin
               e = exp_q.pop_front();
               if (e[0] !== m_si) r_seq_err++;
            end
         end
         if (m_c2 && !pc2) begin
            r_chain = {r_chain[30:0], master};
            r_clk2++;
         end
         if (m_done) begin
            r_ndone++;
            if (r_ndone == 1) r_done_c = c;
            else if (r_ndone == 2) r_done_c2 = c;
         end
         if (pbusy && !m_busy && r_busy_fall == 0) r_busy_fall = c;
         pc1 = m_c1; pc2 = m_c2; pbusy = m_busy; psi = m_si;
         if (c == reset_at) begin
            r_pre_clk1 = m_c1;
            rst_n = 1'b0;
            #1;
            r_rst_c1 = m_c1; r_rst_c2 = m_c2; r_rst_busy = m_busy;
            r_rst_done = m_done; r_rst_si = m_si;
            start_r = 1'b0;
            @(negedge ph1);
            rst_n = 1'b1;
            break;
         end
         start_r = hold ? (r_ndone == 0 || c <= r_done_c + 1) : (c == repulse_at);
         coef_r  = hold ? w : ((c == repulse_at) ? 32'hFFFF_FFFF : $urandom);
         abort_r = (c == abort_at);
         if (!hold && r_busy_fall != 0 && c >= r_busy_fall + 3) break;
         if (hold && r_ndone == 2 && c >= r_done_c2 + 3) break;
         if (c >= 1200) begin
            r_timeout = 1'b1;
            break;
         end
      end
      start_r = 1'b0;
      abort_r = 1'b0;
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic [31:0] coef;
      bit          use_b;
      int          exp_done;
   } vec_t;

   vec_t vecs[5];

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      int bit_idx;
      int bc;
      rst_n = 1'b0; start_r = 1'b0; coef_r = '0; abort_r = 1'b0; sel = 1'b0;

      vecs[0] = '{32'hA53C_0F81, 1'b0, lat(1, 1)};
      vecs[1] = '{$urandom,      1'b1, lat(2, 3)};
      vecs[2] = '{32'h0000_0000, 1'b0, lat(1, 1)};
      vecs[3] = '{32'hFFFF_FFFF, 1'b0, lat(1, 1)};
      vecs[4] = '{$urandom,      1'b0, lat(1, 1)};

      // reset state
      repeat (2) @(negedge ph1);
      chk("rst_busy", busy_a, 0);
      chk("rst_done", done_a, 0);
      chk("rst_clk1", c1_a, 0);
      chk("rst_clk2", c2_a, 0);
      chk("rst_si", si_a, 0);
      chk("rst_state", dbg_a, IDLE);
      chk("rst_busy_b", busy_b, 0);
      rst_n = 1'b1;
      repeat (2) @(negedge ph1);

      // table-driven loads
      for (int i = 0; i < 5; i++) begin
         sel = vecs[i].use_b;
         run_load(vecs[i].coef, -1, -1, -1, 1'b0);
         chk($sformatf("v%0d_timeout", i), r_timeout, 0);
         chk($sformatf("v%0d_done_cycle", i), r_done_c, vecs[i].exp_done);
         chk($sformatf("v%0d_busy_fall", i), r_busy_fall, vecs[i].exp_done + 1);
         chk($sformatf("v%0d_ndone", i), r_ndone, 1);
         chk($sformatf("v%0d_clk2", i), r_clk2, NB);
         chk($sformatf("v%0d_chain", i), r_chain, vecs[i].coef);
         chk($sformatf("v%0d_seq", i), r_seq_err, 0);
         chk($sformatf("v%0d_viol", i), r_viol, 0);
         if (i == 0) begin
            chk("c3", {24'd0, r_chain[31:24]}, 32'hA5);
            chk("c2", {24'd0, r_chain[23:16]}, 32'h3C);
            chk("c1", {24'd0, r_chain[15:8]},  32'h0F);
            chk("c0", {24'd0, r_chain[7:0]},   32'h81);
            chk("si_order", r_seq, 32'b1010_0101_0011_1100_0000_1111_1000_0001);
         end
         repeat (2) @(negedge ph1);
      end
      sel = 1'b0;

      // start re-pulsed mid-load with all ones
      run_load(32'h1234_5678, 40, -1, -1, 1'b0);
      chk("repulse_chain", r_chain, 32'h1234_5678);
      chk("repulse_ndone", r_ndone, 1);
      chk("repulse_done", r_done_c, lat(1, 1));

      // reset mid-load at cycle 77 (bit 15, CLK1 phase)
      run_load(32'hDEAD_BEEF, -1, 77, -1, 1'b0);
      chk("rst77_pre_clk1", r_pre_clk1, 1);
      chk("rst77_clk1", r_rst_c1, 0);
      chk("rst77_clk2", r_rst_c2, 0);
      chk("rst77_busy", r_rst_busy, 0);
      chk("rst77_done", r_rst_done, 0);
      chk("rst77_si", r_rst_si, 0);
      repeat (2) @(negedge ph1);
      run_load(32'h0000_0001, -1, -1, -1, 1'b0);
      chk("post_rst_chain", r_chain, 32'h0000_0001);
      chk("post_rst_done", r_done_c, lat(1, 1));
      repeat (2) @(negedge ph1);

      // back-to-back with start held high
      run_load(32'h5A5A_C3C3, -1, -1, -1, 1'b1);
      chk("b2b_timeout", r_timeout, 0);
      chk("b2b_ndone", r_ndone, 2);
      chk("b2b_done1", r_done_c, lat(1, 1));
      chk("b2b_spacing", r_done_c2 - r_done_c, lat(1, 1) + 1);
      chk("b2b_clk2", r_clk2, 2 * NB);
      chk("b2b_chain", r_chain, 32'h5A5A_C3C3);
      chk("b2b_viol", r_viol, 0);
      repeat (2) @(negedge ph1);

`ifdef COEF_LOADER_ABORT_EN
      // abort during bit 2 CLK1; bit completes, no done
      bc = 1 + 2 * 1 + 2 * 1;
      bit_idx = (12 - 1) / bc;
      run_load(32'hA53C_0F81, -1, -1, 12, 1'b0);
      chk("abort_busy_fall", r_busy_fall, (bit_idx + 1) * bc + 1);
      chk("abort_ndone", r_ndone, 0);
      chk("abort_clk2", r_clk2, bit_idx + 1);
      chk("abort_viol", r_viol, 0);
      repeat (2) @(negedge ph1);
      run_load(32'h0F0F_1234, -1, -1, -1, 1'b0);
      chk("post_abort_chain", r_chain, 32'h0F0F_1234);
`else
      bc = 0;
      bit_idx = 0;
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
